// File: rtl/sdram_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_fetch_sequencer
//
// Walks a width x height image stored contiguously in SDRAM, beginning at
// start_address_sdram. For each pixel it issues one read over a req/ack
// handshake, waits for the returned word, and writes that word into on-chip
// SRAM at the linear pixel index. It pulses done when the frame is complete.
// Only one read is outstanding at any time.
//
// Optional feature (compile-time macro ADDR_BOUND_CHECK_EN):
//   defined   - the walk is checked against finish_address_sdram. A start
//               address above the finish address, or a next address past
//               it, ends the frame in ERR and raises the sticky error flag.
//   undefined - there is no bound comparison and no ERR state. error is tied
//               low and the walk always covers width x height pixels.
//
// Ports:
//   clk, n_rst             clock (rising edge), asynchronous active-low reset
//   start                  frame request, sampled only when idle
//   width, height          frame dimensions, latched on an accepted start
//   start_address_sdram    SDRAM address of pixel (0,0), latched on start
//   finish_address_sdram   last legal SDRAM address (inclusive), latched on start
//   rd_req, rd_addr        read request and address, held until rd_ack
//   rd_ack                 controller accepts the pending request
//   rd_data, rd_data_valid read return data and its qualifier
//   sram_wr_en             one-cycle SRAM write strobe
//   sram_address           SRAM write address (linear pixel index)
//   sram_wr_data           SRAM write data
//   busy                   frame in progress; stays high through the done pulse
//   done                   one-cycle completion pulse
//   error                  bound violation, sticky until the next accepted start
// ---------------------------------------------------------------------------
module sdram_fetch_sequencer #(
    parameter int ADDR_W    = 26,
    parameter int DIM_W     = 13,
    parameter int DATA_W    = 32,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [ADDR_W-1:0] start_address_sdram,
    input  logic [ADDR_W-1:0] finish_address_sdram,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef ADDR_BOUND_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t            state_q;
    logic [DIM_W-1:0]  width_q;
    logic [DIM_W-1:0]  height_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DIM_W-1:0]  col_q;
    logic [DIM_W-1:0]  row_q;
    logic [ADDR_W-1:0] idx_q;
    logic              rd_req_q;
    logic              sram_wr_en_q;
    logic [ADDR_W-1:0] sram_address_q;
    logic [DATA_W-1:0] sram_wr_data_q;
    logic              busy_q;
    logic              done_q;

    // Next-pixel arithmetic
    logic              col_last_d;
    logic              row_last_d;
    logic              pix_last_d;
    logic              dims_zero_d;
    logic              start_accept_d;
    logic [ADDR_W:0]   addr_sum_d;   // one extra bit so an overflow is visible
    logic [ADDR_W-1:0] addr_inc_d;

    assign col_last_d     = (col_q == width_q - DIM_W'(1));
    assign row_last_d     = (row_q == height_q - DIM_W'(1));
    assign pix_last_d     = col_last_d && row_last_d;
    assign dims_zero_d    = (width == '0) || (height == '0);
    // busy_q still covers the done cycle, when the state is already IDLE; this
    // keeps a start in that cycle from being taken.
    assign start_accept_d = (state_q == S_IDLE) && start && !busy_q;
    assign addr_sum_d     = {1'b0, addr_q} + (ADDR_W+1)'(ADDR_STEP);
    assign addr_inc_d     = addr_sum_d[ADDR_W-1:0];

`ifdef ADDR_BOUND_CHECK_EN
    logic [ADDR_W-1:0] finish_q;
    logic              error_q;
    logic              bound_hit_d;
    logic              start_oob_d;

    // A carry out of the address adder counts as passing the bound; the
    // address is never allowed to wrap back into the legal range.
    assign bound_hit_d = addr_sum_d[ADDR_W] || (addr_inc_d > finish_q);
    assign start_oob_d = (start_address_sdram > finish_address_sdram);
    assign error       = error_q;
`else
    logic unused_bound_bits;
    assign unused_bound_bits = ^{finish_address_sdram, addr_sum_d[ADDR_W]};
    assign error             = 1'b0;
`endif

    assign rd_req       = rd_req_q;
    assign rd_addr      = addr_q;
    assign sram_wr_en   = sram_wr_en_q;
    assign sram_address = sram_address_q;
    assign sram_wr_data = sram_wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // NOTE: every register below is written with <= so that all of them
    // update together from the values they had before the clock edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            width_q        <= '0;
            height_q       <= '0;
            addr_q         <= '0;
            col_q          <= '0;
            row_q          <= '0;
            idx_q          <= '0;
            rd_req_q       <= 1'b0;
            sram_wr_en_q   <= 1'b0;
            sram_address_q <= '0;
            sram_wr_data_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef ADDR_BOUND_CHECK_EN
            finish_q       <= '0;
            error_q        <= 1'b0;
`endif
        end else begin
            // NOTE: the pulse outputs default low here each cycle; the case
            // below raises them only in the cycle they belong to.
            sram_wr_en_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start_accept_d) begin
                        width_q  <= width;
                        height_q <= height;
                        addr_q   <= start_address_sdram;
                        col_q    <= '0;
                        row_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef ADDR_BOUND_CHECK_EN
                        finish_q <= finish_address_sdram;
                        error_q  <= 1'b0;
`endif
                        if (dims_zero_d) begin
                            state_q <= S_DONE;
                        end
`ifdef ADDR_BOUND_CHECK_EN
                        else if (start_oob_d) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q  <= S_ISSUE;
                            rd_req_q <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    // rd_req and rd_addr hold steady until the controller acks.
                    if (rd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (rd_data_valid) begin
                        sram_wr_en_q   <= 1'b1;
                        sram_address_q <= idx_q;
                        sram_wr_data_q <= rd_data;
                        idx_q          <= idx_q + ADDR_W'(1);
                        addr_q         <= addr_inc_d;
                        if (col_last_d) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end

                        if (pix_last_d) begin
                            state_q <= S_DONE;
                        end
`ifdef ADDR_BOUND_CHECK_EN
                        else if (bound_hit_d) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
`endif
                        else begin
                            state_q  <= S_ISSUE;
                            rd_req_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // The pulse shows in the following cycle, one cycle after the
                    // final write strobe. busy_q stays high through that cycle.
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

`ifdef ADDR_BOUND_CHECK_EN
                S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
`endif

                default: begin
                    rd_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sdram_fetch_sequencer
//
// Randomised bench for sdram_fetch_sequencer. The bench acts as the SDRAM
// controller, with random ack and data-valid delays. It can also inject
// stray rd_ack, rd_data_valid and start pulses that the design must ignore.
// Expected read addresses, write indices, write data, completion and error
// outcomes come from a frame-level model: pixel p is read from
// start + p*ADDR_STEP, and the walk stops early only when that address would
// pass the finish address.
// ---------------------------------------------------------------------------
module tb_sdram_fetch_sequencer;
    localparam int ADDR_W    = 26;
    localparam int DIM_W     = 13;
    localparam int DATA_W    = 32;
    localparam int ADDR_STEP = 1;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ADDR_W-1:0] start_address_sdram;
    logic [ADDR_W-1:0] finish_address_sdram;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              sram_wr_en;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_wr_data;
    logic              busy;
    logic              done;
    logic              error;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DIM_W    (DIM_W),
        .DATA_W   (DATA_W),
        .ADDR_STEP(ADDR_STEP)
    ) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .start               (start),
        .width               (width),
        .height              (height),
        .start_address_sdram (start_address_sdram),
        .finish_address_sdram(finish_address_sdram),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_ack              (rd_ack),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .sram_wr_en          (sram_wr_en),
        .sram_address        (sram_address),
        .sram_wr_data        (sram_wr_data),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_req"},     64'(rd_req),       64'd0);
        check({tag, "_rd_addr"},    64'(rd_addr),      64'd0);
        check({tag, "_wr_en"},      64'(sram_wr_en),   64'd0);
        check({tag, "_wr_addr"},    64'(sram_address), 64'd0);
        check({tag, "_wr_data"},    64'(sram_wr_data), 64'd0);
        check({tag, "_busy"},       64'(busy),         64'd0);
        check({tag, "_done"},       64'(done),         64'd0);
        check({tag, "_error"},      64'(error),        64'd0);
    endtask

    // Frame-level outcome: how many pixels are read, and whether the frame
    // ends with done or with error.
    function automatic void frame_model(input int w, input int h,
                                        input logic [ADDR_W-1:0] sa,
                                        input logic [ADDR_W-1:0] fa,
                                        output int reads, output bit exp_done,
                                        output bit exp_err, output bit imm_err);
        longint n;
        n        = longint'(w) * longint'(h);
        reads    = int'(n);
        exp_done = 1'b1;
        exp_err  = 1'b0;
        imm_err  = 1'b0;
`ifdef ADDR_BOUND_CHECK_EN
        if (n != 0) begin
            if (sa > fa) begin
                reads    = 0;
                exp_err  = 1'b1;
                imm_err  = 1'b1;
                exp_done = 1'b0;
            end else begin
                longint span;
                span = (longint'(fa) - longint'(sa)) / ADDR_STEP + 1;
                if (span < n) begin
                    reads    = int'(span);
                    exp_err  = 1'b1;
                    exp_done = 1'b0;
                end
            end
        end
`else
        if (sa > fa) reads = int'(n);  // finish address plays no part here
`endif
    endfunction

    task automatic run_frame(input int w, input int h,
                             input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] fa,
                             input int ack_lo, input int ack_hi, input int val_hi,
                             input bit noise, input int reset_at);
        int                exp_reads;
        bit                exp_done, exp_err, imm_err;
        logic [DATA_W-1:0] sent[$];
        logic [ADDR_W-1:0] exp_addr;
        int                reads, writes, dones, cyc, ack_cnt, val_cnt, phase;
        int                last_wr_cyc, done_cyc, err_cyc, tail;
        bit                finished;

        frame_model(w, h, sa, fa, exp_reads, exp_done, exp_err, imm_err);
        reads = 0; writes = 0; dones = 0; ack_cnt = 0; val_cnt = 0; phase = 0;
        last_wr_cyc = 0; done_cyc = 0; err_cyc = 0; tail = 0; finished = 1'b0;
        exp_addr = '0;
        sent.delete();

        @(negedge clk);
        width                = DIM_W'(w);
        height               = DIM_W'(h);
        start_address_sdram  = sa;
        finish_address_sdram = fa;
        start                = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", 64'(busy), 64'd1);
        check("req_latency", 64'(rd_req), 64'(exp_reads > 0));
        check("error_on_start", 64'(error), 64'(imm_err));

        while (tail < 4 && cyc < 2000) begin
            // ---- observe ----
            if (rd_req) begin
                if (phase == 0) begin
                    exp_addr = ADDR_W'(longint'(sa) + longint'(reads) * ADDR_STEP);
                    reads++;
                    ack_cnt = ack_lo + int'($urandom_range(ack_hi - ack_lo));
                    phase   = 1;
                end
                check("rd_addr", 64'(rd_addr), 64'(exp_addr));
                if (phase == 2) check("req_in_wait", 64'(rd_req), 64'd0);
            end
            if (sram_wr_en) begin
                check("wr_addr", 64'(sram_address), 64'(writes));
                check("wr_pending", 64'(sent.size() > 0), 64'd1);
                if (sent.size() > 0) check("wr_data", 64'(sram_wr_data), 64'(sent.pop_front()));
                writes++;
                last_wr_cyc = cyc;
                if (reset_at > 0 && writes == reset_at) begin
                    n_rst = 1'b0;
                    rd_ack = 1'b0; rd_data_valid = 1'b0; start = 1'b0;
                    #1;
                    check_outputs_zero("mid_reset");
                    @(negedge clk);
                    check_outputs_zero("reset_held");
                    n_rst = 1'b1;
                    return;
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (error && err_cyc == 0) err_cyc = cyc;
            if (done || error) finished = 1'b1;
            if (finished) tail++;

            // ---- drive for the next rising edge ----
            rd_ack        = 1'b0;
            rd_data_valid = 1'b0;
            rd_data       = $urandom;
            start         = 1'b0;
            if (phase == 2) begin
                if (val_cnt == 0) begin
                    rd_data_valid = 1'b1;
                    sent.push_back(rd_data);
                    phase = 0;
                end else begin
                    val_cnt--;
                    if (noise) rd_ack = 1'($urandom_range(1));
                end
            end else if (phase == 1) begin
                if (ack_cnt == 0) begin
                    rd_ack  = 1'b1;
                    phase   = 2;
                    val_cnt = int'($urandom_range(val_hi));
                end else begin
                    ack_cnt--;
                end
                if (noise) rd_data_valid = 1'($urandom_range(1));
            end else if (noise && !rd_req) begin
                rd_ack        = 1'($urandom_range(1));
                rd_data_valid = 1'($urandom_range(1));
            end
            if (noise && busy && $urandom_range(3) == 0) begin
                start                = 1'b1;
                width                = DIM_W'($urandom_range(1, 7));
                height               = DIM_W'($urandom_range(1, 7));
                start_address_sdram  = ADDR_W'($urandom);
                finish_address_sdram = ADDR_W'($urandom);
            end

            @(negedge clk);
            cyc++;
        end
        rd_ack = 1'b0; rd_data_valid = 1'b0; start = 1'b0;

        check("frame_finished", 64'(finished), 64'd1);
        check("req_count", 64'(reads), 64'(exp_reads));
        check("wr_count", 64'(writes), 64'(exp_reads));
        check("done_count", 64'(dones), 64'(exp_done));
        check("error_flag", 64'(error), 64'(exp_err));
        check("busy_idle", 64'(busy), 64'd0);
        check("req_idle", 64'(rd_req), 64'd0);
        if (exp_done) check("done_latency", 64'(done_cyc), 64'(exp_reads > 0 ? last_wr_cyc + 1 : 2));
        if (exp_err && !imm_err)
            check("error_timing", 64'(err_cyc == last_wr_cyc || err_cyc == last_wr_cyc + 1), 64'd1);
    endtask

    initial begin
        n_rst                = 1'b0;
        start                = 1'b0;
        width                = '0;
        height               = '0;
        start_address_sdram  = '0;
        finish_address_sdram = '0;
        rd_ack               = 1'b0;
        rd_data              = '0;
        rd_data_valid        = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // Basic 3x2 frame, ack in the first request cycle, data right after.
        run_frame(3, 2, 26'h100, 26'h1FF, 0, 0, 0, 1'b0, 0);
        // Zero width: straight to done, no reads.
        run_frame(0, 5, 26'h100, 26'h1FF, 0, 0, 0, 1'b0, 0);
        // Finish address inside the frame (an early error when bound checking is on).
        run_frame(3, 2, 26'h100, 26'h102, 0, 0, 1, 1'b0, 0);
        // Recovery after an error frame; the finish address is exactly the last pixel.
        run_frame(2, 3, 26'h010, 26'h015, 0, 2, 2, 1'b0, 0);
        // Ack held off for 5 cycles on every request.
        run_frame(2, 2, 26'h200, 26'h2FF, 5, 5, 1, 1'b0, 0);
        // Start address above the finish address.
        run_frame(2, 2, 26'h500, 26'h4FF, 0, 1, 1, 1'b0, 0);
        // Stray start/ack/valid pulses, then a reset after the fourth write.
        run_frame(4, 2, 26'h300, 26'h3FF, 0, 3, 3, 1'b1, 4);
        // A new frame after the reset begins again from index 0.
        run_frame(3, 3, 26'h040, 26'h0FF, 0, 2, 2, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            int                w, h, off;
            logic [ADDR_W-1:0] sa, fa;
            w   = int'($urandom_range(0, 4));
            h   = int'($urandom_range(0, 4));
            sa  = ADDR_W'($urandom_range(0, 32'h000F_FFFF));
            off = int'($urandom_range(0, 20)) - 3;
            fa  = ADDR_W'(longint'(sa) + longint'(off));
            run_frame(w, h, sa, fa, 0, 4, 3, 1'b1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
